// File: rtl/gin_multicast_dispatcher.sv
// GIN receive endpoint: pops {data, tags} from the GIN FIFOs and multicasts each word
// to every PE whose row/column IDs equal the tags, using a per-PE enable/ready handshake.
module gin_multicast_dispatcher #(
   parameter int unsigned NUM_ROWS      = 12,
   parameter int unsigned NUM_COLS      = 14,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ROW_TAG_WIDTH = 4,
   parameter int unsigned COL_TAG_WIDTH = 5
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_ROWS*ROW_TAG_WIDTH-1:0]           row_ids,
   input  logic [NUM_ROWS*NUM_COLS*COL_TAG_WIDTH-1:0]  col_ids,
   input  logic                                        data_fifo_empty,
   input  logic                                        tags_fifo_empty,
   input  logic [DATA_WIDTH-1:0]                       data_fifo_dout,
   input  logic [ROW_TAG_WIDTH+COL_TAG_WIDTH-1:0]      tags_fifo_dout,
   output logic                                        data_fifo_re,
   output logic                                        tags_fifo_re,
   output logic [DATA_WIDTH-1:0]                       pe_data,
   output logic [NUM_ROWS*NUM_COLS-1:0]                pe_enable,
   input  logic [NUM_ROWS*NUM_COLS-1:0]                pe_ready,
   output logic                                        busy,
   output logic                                        drop,
   output logic [15:0]                                 delivered_count
);

   localparam int unsigned NUM_PES = NUM_ROWS * NUM_COLS;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      LOAD,
      DELIVER
   } state_t;

   state_t                     state;
   state_t                     next_state;
   logic                       fifo_pop;
   logic                       fifos_ready;
   logic [ROW_TAG_WIDTH-1:0]   row_tag;
   logic [COL_TAG_WIDTH-1:0]   col_tag;
   logic [NUM_PES-1:0]         match;
   logic [NUM_PES-1:0]         pending;
   logic [NUM_PES-1:0]         pending_after;

   assign {row_tag, col_tag} = tags_fifo_dout;
   assign fifos_ready        = !data_fifo_empty && !tags_fifo_empty;
   assign pending_after      = pending & ~pe_ready;

   // Exact-equality match; multicast arises only from PEs sharing IDs.
   always_comb begin
      match = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         for (int unsigned c = 0; c < NUM_COLS; c++) begin
            match[r*NUM_COLS + c] =
               (row_ids[r*ROW_TAG_WIDTH +: ROW_TAG_WIDTH] == row_tag) &&
               (col_ids[(r*NUM_COLS + c)*COL_TAG_WIDTH +: COL_TAG_WIDTH] == col_tag);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      fifo_pop   = 1'b0;
      pe_enable  = '0;
      case (state)
         IDLE: begin
            if (fifos_ready) next_state = FETCH;
         end
         FETCH: begin
            fifo_pop   = 1'b1;
            next_state = LOAD;
         end
         LOAD: begin
            next_state = (match == '0) ? IDLE : DELIVER;
         end
         DELIVER: begin
            pe_enable = pending;
            if (pending_after == '0) next_state = fifos_ready ? FETCH : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign data_fifo_re = fifo_pop;
   assign tags_fifo_re = fifo_pop;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pe_data         <= '0;
         pending         <= '0;
         drop            <= 1'b0;
         delivered_count <= '0;
      end else begin
         // drop is registered so it lines up with the return to IDLE.
         drop <= (state == LOAD) && (match == '0);
         case (state)
            LOAD: begin
               pe_data <= data_fifo_dout;
               pending <= match;
            end
            DELIVER: begin
               pending <= pending_after;
               if (pending_after == '0) delivered_count <= delivered_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gin_multicast_dispatcher.sv
// Directed bench for gin_multicast_dispatcher with a small two-FIFO source model.
module tb_gin_multicast_dispatcher;

   localparam int unsigned NR = 12;
   localparam int unsigned NC = 14;
   localparam int unsigned NP = NR * NC;
   localparam int unsigned DW = 16;
   localparam int unsigned RW = 4;
   localparam int unsigned CW = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*RW-1:0]  row_ids;
   logic [NP*CW-1:0]  col_ids;
   logic              data_fifo_empty;
   logic              tags_fifo_empty;
   logic [DW-1:0]     data_fifo_dout = '0;
   logic [RW+CW-1:0]  tags_fifo_dout = '0;
   logic              data_fifo_re;
   logic              tags_fifo_re;
   logic [DW-1:0]     pe_data;
   logic [NP-1:0]     pe_enable;
   logic [NP-1:0]     pe_ready;
   logic              busy;
   logic              drop;
   logic [15:0]       delivered_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gin_multicast_dispatcher #(
      .NUM_ROWS(NR), .NUM_COLS(NC), .DATA_WIDTH(DW),
      .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .row_ids(row_ids), .col_ids(col_ids),
      .data_fifo_empty(data_fifo_empty), .tags_fifo_empty(tags_fifo_empty),
      .data_fifo_dout(data_fifo_dout), .tags_fifo_dout(tags_fifo_dout),
      .data_fifo_re(data_fifo_re), .tags_fifo_re(tags_fifo_re),
      .pe_data(pe_data), .pe_enable(pe_enable), .pe_ready(pe_ready),
      .busy(busy), .drop(drop), .delivered_count(delivered_count)
   );

   // FIFO source model: write pointers owned by the stimulus, read pointers by the pop process.
   logic [DW-1:0]    d_mem [0:15];
   logic [RW+CW-1:0] t_mem [0:15];
   int d_wr = 0, d_rd = 0, t_wr = 0, t_rd = 0;

   assign data_fifo_empty = (d_wr == d_rd);
   assign tags_fifo_empty = (t_wr == t_rd);

   always @(posedge clk) begin
      if (data_fifo_re && d_wr != d_rd) begin
         data_fifo_dout <= d_mem[d_rd % 16];
         d_rd <= d_rd + 1;
      end
      if (tags_fifo_re && t_wr != t_rd) begin
         tags_fifo_dout <= t_mem[t_rd % 16];
         t_rd <= t_rd + 1;
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_data(input logic [DW-1:0] d);
      d_mem[d_wr % 16] = d;
      d_wr++;
   endtask

   task automatic push_tags(input logic [RW-1:0] r, input logic [CW-1:0] c);
      t_mem[t_wr % 16] = {r, c};
      t_wr++;
   endtask

   task automatic set_col(input int r, input int c, input logic [CW-1:0] id);
      col_ids[(r*NC + c)*CW +: CW] = id;
   endtask

   logic [NP-1:0] exp;
   logic          seen;
   int            rd0;

   initial begin
      reset    = 1'b0;
      pe_ready = '0;
      for (int r = 0; r < NR; r++) begin
         row_ids[r*RW +: RW] = RW'(r);
         for (int c = 0; c < NC; c++) set_col(r, c, CW'(c));
      end
      tick(2);
      check("rst_busy", busy, 0);
      check("rst_dre", data_fifo_re, 0);
      check("rst_tre", tags_fifo_re, 0);
      check("rst_en", pe_enable, 0);
      check("rst_data", pe_data, 0);
      check("rst_drop", drop, 0);
      check("rst_cnt", delivered_count, 0);
      reset = 1'b1;

      // unicast to PE 3*14+5
      pe_ready = '1;
      push_data(16'hA5A5); push_tags(3, 5);
      tick(1);
      check("uc_dre", data_fifo_re, 1);
      check("uc_tre", tags_fifo_re, 1);
      check("uc_busy", busy, 1);
      tick(2);
      exp = '0; exp[47] = 1'b1;
      check("uc_en", pe_enable, exp);
      check("uc_data", pe_data, 16'hA5A5);
      tick(1);
      check("uc_en_off", pe_enable, 0);
      check("uc_cnt", delivered_count, 1);
      check("uc_idle", busy, 0);

      // whole-row multicast
      for (int c = 0; c < NC; c++) set_col(2, c, 0);
      push_data(16'h1234); push_tags(2, 0);
      tick(3);
      exp = '0;
      for (int c = 0; c < NC; c++) exp[28 + c] = 1'b1;
      check("row_en", pe_enable, exp);
      check("row_data", pe_data, 16'h1234);
      tick(1);
      check("row_en_off", pe_enable, 0);
      check("row_cnt", delivered_count, 2);
      for (int c = 0; c < NC; c++) set_col(2, c, CW'(c));

      // staggered ready on PEs 57, 59, 62, 65
      pe_ready = '0;
      set_col(4, 1, 20); set_col(4, 3, 20); set_col(4, 6, 20); set_col(4, 9, 20);
      push_data(16'hBEEF); push_tags(4, 20);
      tick(3);
      pe_ready[57] = 1'b1;
      exp = '0; exp[57] = 1'b1; exp[59] = 1'b1; exp[62] = 1'b1; exp[65] = 1'b1;
      check("stg_c0", pe_enable, exp);
      tick(1);
      pe_ready[57] = 1'b0;
      exp[57] = 1'b0;
      check("stg_c1", pe_enable, exp);
      tick(1);
      pe_ready[59] = 1'b1; pe_ready[62] = 1'b1;
      check("stg_c2", pe_enable, exp);
      tick(1);
      pe_ready[59] = 1'b0; pe_ready[62] = 1'b0;
      exp = '0; exp[65] = 1'b1;
      check("stg_c3", pe_enable, exp);
      check("stg_data3", pe_data, 16'hBEEF);
      tick(3);
      check("stg_c6", pe_enable, exp);
      check("stg_busy6", busy, 1);
      tick(1);
      pe_ready[65] = 1'b1;
      check("stg_c7", pe_enable, exp);
      check("stg_data7", pe_data, 16'hBEEF);
      tick(1);
      check("stg_en_off", pe_enable, 0);
      check("stg_idle", busy, 0);
      check("stg_cnt", delivered_count, 3);
      set_col(4, 1, 1); set_col(4, 3, 3); set_col(4, 6, 6); set_col(4, 9, 9);

      // no match: drop pulse, one pop
      pe_ready = '1;
      rd0 = d_rd;
      push_data(16'h7777); push_tags(15, 31);
      tick(1);
      check("nm_re", data_fifo_re, 1);
      tick(1);
      check("nm_drop_load", drop, 0);
      tick(1);
      check("nm_drop", drop, 1);
      check("nm_en", pe_enable, 0);
      check("nm_idle", busy, 0);
      tick(1);
      check("nm_drop_off", drop, 0);
      check("nm_cnt", delivered_count, 3);
      check("nm_pops", d_rd - rd0, 1);
      check("nm_tpops", t_rd - t_wr, 0);

      // tags present, data absent: no pop, stays idle
      push_tags(1, 1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         seen = seen | data_fifo_re | tags_fifo_re | busy;
      end
      check("eg_quiet", seen, 0);
      push_data(16'h0F0F);
      tick(1);
      check("eg_dre", data_fifo_re, 1);
      check("eg_tre", tags_fifo_re, 1);
      tick(2);
      exp = '0; exp[15] = 1'b1;
      check("eg_en", pe_enable, exp);
      check("eg_data", pe_data, 16'h0F0F);
      tick(1);
      check("eg_cnt", delivered_count, 4);

      // reset mid-DELIVER with 2 of 5 PEs (84..88) served
      pe_ready = '0;
      for (int c = 0; c < 5; c++) set_col(6, c, 25);
      push_data(16'h1111); push_tags(6, 25);
      push_data(16'h2222); push_tags(6, 25);
      tick(3);
      pe_ready[84] = 1'b1; pe_ready[85] = 1'b1;
      exp = '0;
      for (int k = 84; k <= 88; k++) exp[k] = 1'b1;
      check("rd_c0", pe_enable, exp);
      tick(1);
      pe_ready = '0;
      exp[84] = 1'b0; exp[85] = 1'b0;
      check("rd_c1", pe_enable, exp);
      #2 reset = 1'b0;
      #1;
      check("rd_async_en", pe_enable, 0);
      check("rd_async_busy", busy, 0);
      check("rd_async_cnt", delivered_count, 0);
      @(negedge clk);
      reset = 1'b1;
      pe_ready = '1;
      tick(1);
      check("rd_re", data_fifo_re, 1);
      tick(2);
      for (int k = 84; k <= 88; k++) exp[k] = 1'b1;
      check("rd_en", pe_enable, exp);
      check("rd_data", pe_data, 16'h2222);
      tick(1);
      check("rd_cnt", delivered_count, 1);
      check("rd_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gin_multicast_dispatcher.md
# gin_multicast_dispatcher

Receive-side endpoint of the global input network (GIN). The block pops data words and their row/column tags from the GIN data FIFO and the tags FIFO, both filled by the NoC controller. It multicasts each word to every PE whose configured row ID and column ID match the tags, using a per-PE enable/ready handshake. One instance serves each data type (ifmap, filter, ipsum), sitting between the GIN FIFOs and the PE array.

## Interface
Parameters:
- NUM_ROWS, 12, PE array rows (Y-bus count)
- NUM_COLS, 14, PEs per row
- DATA_WIDTH, 16, GIN data FIFO output width
- ROW_TAG_WIDTH, 4, row tag / row ID width
- COL_TAG_WIDTH, 5, column tag / column ID width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- row_ids  in  NUM_ROWS*ROW_TAG_WIDTH  per-row ID; row i at slice i; static while busy
- col_ids  in  NUM_ROWS*NUM_COLS*COL_TAG_WIDTH  per-PE column ID; PE k = row*NUM_COLS+col; static while busy
- data_fifo_empty  in  1  GIN data FIFO empty
- tags_fifo_empty  in  1  tags FIFO empty
- data_fifo_dout  in  DATA_WIDTH  data FIFO read data; valid the cycle after data_fifo_re
- tags_fifo_dout  in  ROW_TAG_WIDTH+COL_TAG_WIDTH  {row_tag, col_tag}; valid the cycle after tags_fifo_re
- data_fifo_re  out  1  pop data FIFO
- tags_fifo_re  out  1  pop tags FIFO
- pe_data  out  DATA_WIDTH  word broadcast to all PEs
- pe_enable  out  NUM_ROWS*NUM_COLS  per-PE valid
- pe_ready  in  NUM_ROWS*NUM_COLS  per-PE ready
- busy  out  1  high in any state except IDLE
- drop  out  1  one-cycle pulse when a packet matched no PE
- delivered_count  out  16  packets fully delivered since reset; wraps at 0xFFFF

## Operation
- States: IDLE, FETCH, LOAD, DELIVER.
- IDLE: if !data_fifo_empty && !tags_fifo_empty -> FETCH; else stay.
- FETCH: assert data_fifo_re and tags_fifo_re together for exactly one cycle -> LOAD. The two FIFOs are never popped separately.
- LOAD: register data_fifo_dout into pe_data; compute pending mask bit k = (row_ids[row(k)] == row_tag) && (col_ids[k] == col_tag). If the mask is zero, pulse drop and -> IDLE. Otherwise -> DELIVER.
- DELIVER: pe_enable = pending. PE k accepts when pe_enable[k] && pe_ready[k] in the same cycle; clear pending[k] at that edge. Any number of PEs may accept in one cycle.
- When the next-cycle pending is zero: increment delivered_count. Then go to FETCH if both FIFOs are non-empty, else to IDLE.
- A ready PE outside pending is never enabled. pe_enable never asserts outside DELIVER.
- pe_data is held stable for the whole of DELIVER.
- Tag compare is exact equality. There are no wildcard tags; multicast comes from several PEs sharing the same IDs.

## Timing
- Reset (async assert, sync deassert internally assumed by top): state=IDLE, data_fifo_re=0, tags_fifo_re=0, pe_enable=0, pe_data=0, busy=0, drop=0, delivered_count=0, pending=0.
- Reset mid-DELIVER discards the packet. The FIFOs are not rewound.
- Latency, FIFO non-empty to first pe_enable: 3 cycles (IDLE -> FETCH -> LOAD -> DELIVER). From DELIVER the block goes straight to FETCH, so back-to-back throughput is one packet per 3 cycles when all targets are ready.
- data_fifo_re and tags_fifo_re are combinational from state (FETCH) and never assert while either empty flag was high in the preceding IDLE/DELIVER decision cycle.
- drop is high only in the cycle after LOAD, i.e. registered and aligned to the IDLE entry.
- delivered_count updates on the edge leaving DELIVER.

## Test plan
- Single unicast: IDs row r=3, col c=5; push data 0xA5A5, tags {3,5}; all ready -> pe_enable only bit 3*14+5 for exactly 1 cycle, 3 cycles after push visible; delivered_count=1.
- Row multicast: all PEs in row 2 have col ID 0; push {2,0}, data 0x1234 -> 14 enable bits high one cycle; pe_data=0x1234.
- Staggered ready: 4 matched PEs, ready asserted at cycles 0,2,2,7 of DELIVER -> each enable drops the cycle after its accept; DELIVER lasts 8 cycles; pe_data stable throughout.
- No match: push tags {15,31} with no matching IDs -> drop pulses once, no pe_enable, delivered_count unchanged, FIFOs popped once.
- Empty gating: tags FIFO non-empty, data FIFO empty for 10 cycles -> no re asserted, busy=0; when data arrives, both re assert in the same cycle.
- Reset mid-DELIVER: drive reset low with 2 of 5 PEs served -> pe_enable=0 and busy=0 immediately (async). After release, the next queued packet is delivered normally and delivered_count restarts from 0.
